// File: rtl/shadowmask_loader_if.sv
// Pattern-memory read port and shadow-mask config write port of shadowmask_loader.
interface shadowmask_loader_if #(
    parameter int SEL_W = 1
);
    // rom_data is valid the cycle after rom_addr is presented; mask_wr is a one-cycle
    // strobe qualifying mask_data, and the shadow-mask stage always accepts it.
    logic [SEL_W+8:0] rom_addr;
    logic [15:0]      rom_data;
    logic             mask_wr;
    logic [15:0]      mask_data;

    modport master (output rom_addr, output mask_wr, output mask_data, input rom_data);
    modport slave  (input rom_addr, input mask_wr, input mask_data, output rom_data);
endinterface

// File: rtl/shadowmask_loader.sv
// Replays a stored shadow-mask pattern as RST, VMAX, HMAX and 16 ENTRY words per row.
// Optional header magic check: define SHADOWMASK_LOADER_MAGIC_EN.
module shadowmask_loader #(
    parameter int SEL_W  = 1,
    parameter int WR_GAP = 0
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                start,
    input  logic [SEL_W-1:0]    mask_sel,
    shadowmask_loader_if.master bus,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [3:0]          state_dbg
);
    typedef enum logic [3:0] {
        IDLE, HDR_RD, HDR_WAIT, SEND_RST, SEND_V, SEND_H,
        ENT_RD, ENT_WR, PAD_WR, GAP, FIN
    } state_t;

    localparam logic [7:0] GAP_LAST = 8'((WR_GAP > 0) ? WR_GAP - 1 : 0);

    state_t           state, state_next, follow, ret_d, ret_q;
    logic [SEL_W-1:0] sel_q;
    logic [8:0]       offset;
    logic [3:0]       vmax_q, hmax_q, h, v, h_inc;
    logic [7:0]       gap_cnt;
    logic             wr_state, last, issue_rd, hdr_bad;
    logic [15:0]      wr_word;
    logic             unused_hdr;

    assign state_dbg  = state;
    assign unused_hdr = ^bus.rom_data[15:11];

`ifdef SHADOWMASK_LOADER_MAGIC_EN
    assign hdr_bad = (bus.rom_data[15:8] != 8'hA5);
`else
    assign hdr_bad = 1'b0;
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        h_inc      = h + 4'd1;
        last       = (h == 4'hF) && (v == vmax_q);
        wr_state   = 1'b0;
        follow     = IDLE;
        wr_word    = 16'h0000;
        state_next = state;
        case (state)
            SEND_RST: begin wr_state = 1'b1; follow = SEND_V; end
            SEND_V: begin
                wr_state = 1'b1;
                follow   = SEND_H;
                wr_word  = {3'b001, 9'b0, vmax_q};
            end
            SEND_H: begin
                wr_state = 1'b1;
                follow   = ENT_RD;
                wr_word  = {3'b010, 9'b0, hmax_q};
            end
            ENT_WR, PAD_WR: begin
                wr_state = 1'b1;
                wr_word  = (state == ENT_WR) ? {5'b01100, bus.rom_data[10:0]} : 16'h6000;
                // After h wraps to 0 the new row always starts with a stored entry.
                if (last)                 follow = FIN;
                else if (h_inc <= hmax_q) follow = ENT_RD;
                else                      follow = PAD_WR;
            end
            default: ;
        endcase
        issue_rd = wr_state && (follow == ENT_RD);
        // With a gap the read overlaps the idle cycles, so resume at the write.
        ret_d    = (follow == ENT_RD) ? ENT_WR : follow;

        case (state)
            IDLE:     if (start) state_next = HDR_RD;
            HDR_RD:   state_next = HDR_WAIT;
            HDR_WAIT: state_next = hdr_bad ? FIN : SEND_RST;
            ENT_RD:   state_next = ENT_WR;
            GAP:      if (gap_cnt == GAP_LAST) state_next = ret_q;
            FIN:      state_next = IDLE;
            default:  if (wr_state) state_next = (WR_GAP > 0) ? GAP : follow;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            bus.rom_addr  <= '0;
            bus.mask_wr   <= 1'b0;
            bus.mask_data <= 16'h0000;
            busy          <= 1'b0;
            done          <= 1'b0;
            sel_q         <= '0;
            offset        <= 9'd0;
            vmax_q        <= 4'd0;
            hmax_q        <= 4'd0;
            h             <= 4'd0;
            v             <= 4'd0;
            gap_cnt       <= 8'd0;
            ret_q         <= IDLE;
        end else begin
            bus.mask_wr <= 1'b0;
            done        <= 1'b0;
            if (state == IDLE && start) begin
                busy         <= 1'b1;
                sel_q        <= mask_sel;
                bus.rom_addr <= {mask_sel, 9'd0};
                offset       <= 9'd1;
                h            <= 4'd0;
                v            <= 4'd0;
            end
            if (state == HDR_WAIT) begin
                vmax_q <= bus.rom_data[3:0];
                hmax_q <= bus.rom_data[7:4];
            end
            if (wr_state) begin
                bus.mask_wr   <= 1'b1;
                bus.mask_data <= wr_word;
                ret_q         <= ret_d;
                gap_cnt       <= 8'd0;
            end
            if (state == ENT_WR || state == PAD_WR) begin
                h <= h_inc;
                if (h == 4'hF) v <= v + 4'd1;
            end
            if (state == GAP) gap_cnt <= gap_cnt + 8'd1;
            // Offset only advances on real-entry reads; 256 entries end at offset 256.
            if (issue_rd) begin
                bus.rom_addr <= {sel_q, offset};
                offset       <= offset + 9'd1;
            end
            if (state == FIN) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

`ifdef SHADOWMASK_LOADER_MAGIC_EN
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)                         err <= 1'b0;
        else if (state == IDLE && start)   err <= 1'b0;
        else if (state == HDR_WAIT && hdr_bad) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_shadowmask_loader.sv
// Bench for shadowmask_loader: back-to-back instance and WR_GAP=2 instance fed from one pattern memory.
module tb_shadowmask_loader;
    localparam int SEL_W = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic             start_a = 1'b0, start_b = 1'b0;
    logic [SEL_W-1:0] sel_a = '0, sel_b = '0;
    logic             busy_a, done_a, err_a, busy_b, done_b, err_b;
    logic [3:0]       state_a, state_b;

    shadowmask_loader_if #(.SEL_W(SEL_W)) bus_a ();
    shadowmask_loader_if #(.SEL_W(SEL_W)) bus_b ();

    shadowmask_loader #(.SEL_W(SEL_W), .WR_GAP(0)) dut_a (
        .clk_sys(clk), .reset(rst), .start(start_a), .mask_sel(sel_a), .bus(bus_a),
        .busy(busy_a), .done(done_a), .err(err_a), .state_dbg(state_a)
    );
    shadowmask_loader #(.SEL_W(SEL_W), .WR_GAP(2)) dut_b (
        .clk_sys(clk), .reset(rst), .start(start_b), .mask_sel(sel_b), .bus(bus_b),
        .busy(busy_b), .done(done_b), .err(err_b), .state_dbg(state_b)
    );

    // Synchronous pattern memory, one read port per loader
    logic [15:0] mem [0:1023];
    always @(posedge clk) begin
        bus_a.rom_data <= mem[bus_a.rom_addr];
        bus_b.rom_data <= mem[bus_b.rom_addr];
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    // Reference model: the full write list a load of slot sel must produce
    logic [15:0] model_q[$];
    task automatic build_model(input int sel);
        int base, vm, hm;
        logic [15:0] hdr;
        base = sel * 512;
        hdr  = mem[base];
        vm   = int'(hdr[3:0]);
        hm   = int'(hdr[7:4]);
        model_q.delete();
`ifdef SHADOWMASK_LOADER_MAGIC_EN
        if (hdr[15:8] != 8'hA5) return;
`endif
        model_q.push_back(16'h0000);
        model_q.push_back(16'h2000 | 16'(vm));
        model_q.push_back(16'h4000 | 16'(hm));
        for (int r = 0; r <= vm; r++)
            for (int c = 0; c < 16; c++)
                if (c <= hm) model_q.push_back(16'h6000 | (mem[base + 1 + r * (hm + 1) + c] & 16'h07FF));
                else         model_q.push_back(16'h6000);
    endtask

    task automatic fill_slot(input int sel, input int vm, input int hm);
        mem[sel * 512] = {8'hA5, 4'(hm), 4'(vm)};
        for (int i = 1; i <= (vm + 1) * (hm + 1); i++) mem[sel * 512 + i] = 16'($urandom);
    endtask

    // Scoreboard state
    logic [15:0] exp_a[$], exp_b[$];
    int n_a = -100, n_b = -100;
    int wr_cnt_a, first_wr_a, last_wr_a, done_cnt_a, done_cyc_a, max_addr_a;
    int wr_cnt_b, prev_wr_b, done_cnt_b;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_a.mask_wr) begin
                wr_cnt_a++;
                last_wr_a = cyc;
                if (wr_cnt_a == 1) first_wr_a = cyc;
                if (exp_a.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL a_extra_write: got %0h, expected no write", bus_a.mask_data);
                end else chk("a_wr_data", bus_a.mask_data, exp_a.pop_front());
            end
            if (done_a && cyc > n_a) begin done_cnt_a++; done_cyc_a = cyc; end
            if (busy_a && int'(bus_a.rom_addr) > max_addr_a) max_addr_a = int'(bus_a.rom_addr);

            if (bus_b.mask_wr) begin
                wr_cnt_b++;
                if (prev_wr_b >= 0) chk("b_wr_spacing", cyc - prev_wr_b, 3);
                prev_wr_b = cyc;
                if (exp_b.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL b_extra_write: got %0h, expected no write", bus_b.mask_data);
                end else chk("b_wr_data", bus_b.mask_data, exp_b.pop_front());
            end
            if (done_b && cyc > n_b) done_cnt_b++;
        end
    end

    int exp_len;

    // Called just after a posedge; start is sampled at the next edge (cycle n)
    task automatic do_load(input int sel, input bit with_b);
        build_model(sel);
        exp_len = model_q.size();
        foreach (model_q[i]) exp_a.push_back(model_q[i]);
        wr_cnt_a = 0; done_cnt_a = 0; max_addr_a = 0; first_wr_a = -1;
        n_a = cyc + 1;
        start_a = 1'b1;
        sel_a = SEL_W'(sel);
        if (with_b) begin
            foreach (model_q[i]) exp_b.push_back(model_q[i]);
            wr_cnt_b = 0; prev_wr_b = -1; done_cnt_b = 0;
            n_b = cyc + 1;
            start_b = 1'b1;
            sel_b = SEL_W'(sel);
        end
        @(posedge clk); #2;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input bit with_b);
        int k;
        k = 0;
        while ((done_cnt_a == 0 || (with_b && done_cnt_b == 0)) && k < 3000) begin
            @(posedge clk); #2;
            k++;
        end
        chk("done_timeout", 32'(k < 3000), 1);
    endtask

    task automatic check_load(input int nwr, input bit with_b);
        chk("a_exp_left", exp_a.size(), 0);
        chk("a_write_count", wr_cnt_a, nwr);
        chk("a_rst_at_n3", first_wr_a, n_a + 3);
        chk("a_done_after_last", done_cyc_a, last_wr_a + 1);
        chk("a_busy_after_done", busy_a, 0);
        chk("a_err", err_a, 0);
        if (with_b) begin
            int k;
            k = 0;
            while (done_cnt_b == 0 && k < 100) begin @(posedge clk); #2; k++; end
            chk("b_exp_left", exp_b.size(), 0);
            chk("b_write_count", wr_cnt_b, nwr);
        end
        repeat (3) @(posedge clk);
        #2;
        chk("a_done_once", done_cnt_a, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k, s, vm, hm;
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_mask_wr", bus_a.mask_wr, 0);
        chk("rst_mask_data", bus_a.mask_data, 0);
        chk("rst_rom_addr", bus_a.rom_addr, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        rst = 1'b0;
        @(posedge clk); #2;

        // Pattern from the reference example, model pinned against literals
        mem[0] = 16'hA511;
        mem[1] = 16'h070F; mem[2] = 16'h000C; mem[3] = 16'h000C; mem[4] = 16'h070F;
        build_model(0);
        chk("model_len35", model_q.size(), 35);
        chk("model_w1", model_q[1], 16'h2001);
        chk("model_w3", model_q[3], 16'h670F);
        chk("model_w4", model_q[4], 16'h600C);
        chk("model_w5", model_q[5], 16'h6000);
        chk("model_w19", model_q[19], 16'h600C);
        chk("model_w20", model_q[20], 16'h670F);
        chk("model_w34", model_q[34], 16'h6000);
        do_load(0, 1);
        wait_done(1);
        check_load(35, 1);

        // Full 16x16 pattern: last read at offset 256
        fill_slot(1, 15, 15);
        do_load(1, 1);
        wait_done(1);
        check_load(259, 1);
        chk("max_rom_addr", max_addr_a, 512 + 256);

        // Single-entry pattern
        mem[0] = 16'hA500;
        mem[1] = 16'h07FF;
        build_model(0);
        chk("model1_len19", model_q.size(), 19);
        chk("model1_w3", model_q[3], 16'h67FF);
        do_load(0, 1);
        wait_done(1);
        check_load(19, 1);

        // Starts while busy are ignored
        fill_slot(1, 5, 9);
        fill_slot(0, 2, 3);
        do_load(1, 0);
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(3, 10)) @(posedge clk);
            #2;
            if (busy_a) begin
                start_a = 1'b1;
                sel_a = 1'b0;
                @(posedge clk); #2;
                start_a = 1'b0;
            end
        end
        wait_done(0);
        check_load(3 + 16 * 6, 0);

        // Start accepted in the same cycle as done
        do_load(0, 0);
        k = 0;
        while (!done_a && k < 2000) begin @(posedge clk); #2; k++; end
        chk("b2b_done_seen", done_a, 1);
        chk("b2b_first_count", wr_cnt_a, 3 + 16 * 3);
        do_load(1, 0);
        wait_done(0);
        check_load(3 + 16 * 6, 0);

        // Asynchronous reset mid-load, then a full replay
        mem[0] = 16'hA511;
        mem[1] = 16'h070F; mem[2] = 16'h000C; mem[3] = 16'h000C; mem[4] = 16'h070F;
        do_load(0, 1);
        k = 0;
        while (wr_cnt_a < 10 && k < 200) begin @(posedge clk); #2; k++; end
        chk("mid_load_reached", 32'(wr_cnt_a >= 10), 1);
        rst = 1'b1;
        #1;
        chk("arst_mask_wr", bus_a.mask_wr, 0);
        chk("arst_mask_data", bus_a.mask_data, 0);
        chk("arst_rom_addr", bus_a.rom_addr, 0);
        chk("arst_busy", busy_a, 0);
        chk("arst_b_busy", busy_b, 0);
        exp_a.delete();
        exp_b.delete();
        @(posedge clk); #2;
        chk("arst_hold_wr", bus_a.mask_wr, 0);
        chk("arst_hold_done", done_a, 0);
        rst = 1'b0;
        @(posedge clk); #2;
        do_load(0, 1);
        wait_done(1);
        check_load(35, 1);

        // Randomized patterns
        for (int t = 0; t < 8; t++) begin
            s  = int'($urandom_range(0, 1));
            vm = int'($urandom_range(0, 7));
            hm = int'($urandom_range(0, 15));
            fill_slot(s, vm, hm);
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #2;
            do_load(s, 1);
            wait_done(1);
            check_load(3 + 16 * (vm + 1), 1);
        end

`ifdef SHADOWMASK_LOADER_MAGIC_EN
        // Bad header magic aborts with no writes, then a good start clears err
        mem[0] = 16'h0011;
        do_load(0, 0);
        wait_done(0);
        chk("magic_no_writes", wr_cnt_a, 0);
        chk("magic_err", err_a, 1);
        chk("magic_done_n3", done_cyc_a, n_a + 3);
        mem[0] = 16'hA511;
        do_load(0, 0);
        chk("magic_err_cleared", err_a, 0);
        wait_done(0);
        check_load(35, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
